// File: rtl/yapp_tx_pkg.sv
// yapp_tx_pkg: shared state type, limits and header packing for the
// YAPP transmit engine.
package yapp_tx_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WAIT,
      PAY,
      PAR,
      GAP
   } yapp_tx_state_e;

   localparam int YAPP_MAX_LEN = 63;
   localparam int YAPP_LEN_W   = $clog2(YAPP_MAX_LEN + 1);

   function automatic logic [7:0] yapp_hdr(
      input logic [1:0]            addr,
      input logic [YAPP_LEN_W-1:0] len
   );
      return {len, addr};
   endfunction

endpackage

// File: rtl/yapp_tx_fifo.sv
// yapp_tx_fifo: synchronous show-ahead byte FIFO; head byte is always
// visible on o_data while not empty.
module yapp_tx_fifo #(
   parameter int DEPTH = 64,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic          i_clock,
   input  logic          i_reset_n,
   input  logic          i_push,
   input  logic [7:0]    i_data,
   input  logic          i_pop,
   output logic [7:0]    o_data,
   output logic          o_full,
   output logic          o_empty,
   output logic [AW:0]   o_count
);

   logic [7:0]    r_mem [DEPTH];
   logic [AW-1:0] r_wr;
   logic [AW-1:0] r_rd;
   logic [AW:0]   r_cnt;
   logic          w_push;
   logic          w_pop;

   assign o_full  = (r_cnt == (AW+1)'(DEPTH));
   assign o_empty = (r_cnt == '0);
   assign o_count = r_cnt;
   assign o_data  = r_mem[r_rd];

   assign w_push = i_push && !o_full;
   assign w_pop  = i_pop && !o_empty;

   always_ff @(posedge i_clock) begin
      if (w_push) r_mem[r_wr] <= i_data;
   end

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_wr  <= '0;
         r_rd  <= '0;
         r_cnt <= '0;
      end else begin
         if (w_push) r_wr <= r_wr + AW'(1);
         if (w_pop)  r_rd <= r_rd + AW'(1);
         unique case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
            2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
            default: r_cnt <= r_cnt;
         endcase
      end
   end

endmodule

// File: rtl/yapp_tx_engine.sv
// yapp_tx_engine: frames buffered payload into YAPP packets for the router.
// Optional YAPP_TX_PERR_EN adds inject_perr to corrupt a packet's parity.
module yapp_tx_engine
   import yapp_tx_pkg::*;
#(
   parameter int GAP_CYCLES = 1,
   parameter int FIFO_DEPTH = 64,
   parameter int CNT_W      = 16
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  req_vld,
   output logic                  req_rdy,
   input  logic [1:0]            req_addr,
   input  logic [YAPP_LEN_W-1:0] req_len,
`ifdef YAPP_TX_PERR_EN
   input  logic                  inject_perr,
`endif
   input  logic [7:0]            pay_data,
   input  logic                  pay_vld,
   output logic                  pay_rdy,
   output logic [7:0]            in_data,
   output logic                  in_data_vld,
   input  logic                  in_suspend,
   output logic                  busy,
   output logic                  pkt_done,
   output logic [CNT_W-1:0]      pkt_count
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

   yapp_tx_state_e        r_state;
   yapp_tx_state_e        w_next;
   logic [1:0]            r_addr;
   logic [YAPP_LEN_W-1:0] r_len;
   logic [YAPP_LEN_W-1:0] r_rem;
   logic [7:0]            r_data;
   logic                  r_vld;
   logic [7:0]            r_par;
   logic                  r_is_par;
   logic [GW-1:0]         r_gap;
   logic                  r_done;
   logic [CNT_W-1:0]      r_count;

   logic                  w_xfer;
   logic                  w_ready;
   logic                  w_pop;
   logic                  w_push;
   logic [7:0]            w_head;
   logic                  w_full;
   logic                  w_empty;
   logic [AW:0]           w_count;
   logic [7:0]            w_hdr;
   logic [7:0]            w_par_out;

`ifdef YAPP_TX_PERR_EN
   logic                  r_perr;
   assign w_par_out = r_par ^ {8{r_perr}};
`else
   assign w_par_out = r_par;
`endif

   // Gating with reset keeps both handshakes low while reset is held.
   assign req_rdy = reset && (r_state == IDLE);
   assign pay_rdy = reset && !w_full;

   assign in_data     = r_data;
   assign in_data_vld = r_vld;
   assign busy        = (r_state != IDLE);
   assign pkt_done    = r_done;
   assign pkt_count   = r_count;

   assign w_xfer  = r_vld && !in_suspend;
   assign w_ready = (w_count >= (AW+1)'(r_len));
   assign w_pop   = (r_state == PAY) && w_xfer && !w_empty;
   assign w_push  = pay_vld && pay_rdy;
   assign w_hdr   = yapp_hdr(r_addr, r_len);

   yapp_tx_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_clock   (clock),
      .i_reset_n (reset),
      .i_push    (w_push),
      .i_data    (pay_data),
      .i_pop     (w_pop),
      .o_data    (w_head),
      .o_full    (w_full),
      .o_empty   (w_empty),
      .o_count   (w_count)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) r_state <= IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE: if (req_vld) w_next = WAIT;
         WAIT: if (w_ready) w_next = (r_len == '0) ? PAR : PAY;
         PAY:  if (w_xfer && r_rem == YAPP_LEN_W'(1)) w_next = PAR;
         PAR:  if (w_xfer && r_is_par) w_next = GAP;
         GAP:  if (r_gap == GAP_LAST) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_addr   <= '0;
         r_len    <= '0;
         r_rem    <= '0;
         r_data   <= '0;
         r_vld    <= 1'b0;
         r_par    <= '0;
         r_is_par <= 1'b0;
         r_gap    <= '0;
         r_done   <= 1'b0;
         r_count  <= '0;
`ifdef YAPP_TX_PERR_EN
         r_perr   <= 1'b0;
`endif
      end else begin
         r_done <= 1'b0;
         unique case (r_state)
            IDLE: if (req_vld) begin
               r_addr <= req_addr;
               r_len  <= req_len;
`ifdef YAPP_TX_PERR_EN
               r_perr <= inject_perr;
`endif
            end
            WAIT: if (w_ready) begin
               r_data   <= w_hdr;
               r_vld    <= 1'b1;
               r_par    <= w_hdr;
               r_rem    <= r_len;
               r_is_par <= 1'b0;
            end
            PAY: if (w_xfer) begin
               r_data <= w_head;
               r_par  <= r_par ^ w_head;
               r_rem  <= r_rem - YAPP_LEN_W'(1);
            end
            // First transfer here retires the last data byte; second retires parity.
            PAR: if (w_xfer) begin
               if (!r_is_par) begin
                  r_data   <= w_par_out;
                  r_is_par <= 1'b1;
               end else begin
                  r_vld   <= 1'b0;
                  r_done  <= 1'b1;
                  r_count <= r_count + CNT_W'(1);
                  r_gap   <= '0;
               end
            end
            GAP: r_gap <= r_gap + GW'(1);
            default: r_gap <= '0;
         endcase
      end
   end

endmodule

// File: tb/tb_yapp_tx_engine.sv
// tb_yapp_tx_engine: directed scoreboard bench for yapp_tx_engine.
// Define YAPP_TX_PERR_EN to also exercise parity corruption.
module tb_yapp_tx_engine;

   localparam int GAP = 1;

   logic         clock = 1'b0;
   logic         reset = 1'b0;
   logic         req_vld = 1'b0;
   logic         req_rdy;
   logic [1:0]   req_addr = '0;
   logic [5:0]   req_len = '0;
`ifdef YAPP_TX_PERR_EN
   logic         inject_perr = 1'b0;
`endif
   logic [7:0]   pay_data = '0;
   logic         pay_vld = 1'b0;
   logic         pay_rdy;
   logic [7:0]   in_data;
   logic         in_data_vld;
   logic         in_suspend = 1'b0;
   logic         busy;
   logic         pkt_done;
   logic [15:0]  pkt_count;

   logic [7:0]   exp_q[$];
   int           checks = 0;
   int           errors = 0;
   int           run_len = 0;
   int           last_run = 0;
   int           low_run = 100;
   int           last_low = 0;

   yapp_tx_engine #(
      .GAP_CYCLES (GAP),
      .FIFO_DEPTH (64),
      .CNT_W      (16)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .req_vld     (req_vld),
      .req_rdy     (req_rdy),
      .req_addr    (req_addr),
      .req_len     (req_len),
`ifdef YAPP_TX_PERR_EN
      .inject_perr (inject_perr),
`endif
      .pay_data    (pay_data),
      .pay_vld     (pay_vld),
      .pay_rdy     (pay_rdy),
      .in_data     (in_data),
      .in_data_vld (in_data_vld),
      .in_suspend  (in_suspend),
      .busy        (busy),
      .pkt_done    (pkt_done),
      .pkt_count   (pkt_count)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Wire monitor: every transferring byte is popped from the scoreboard.
   initial begin
      forever begin
         @(negedge clock);
         if (!reset) begin
            run_len = 0;
            low_run = 100;
         end else if (in_data_vld) begin
            if (run_len == 0) begin
               last_low = low_run;
               low_run  = 0;
            end
            run_len++;
            if (!in_suspend) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $error("FAIL wire_byte observed=%0h expected=none", in_data);
               end else begin
                  chk("wire_byte", 32'(in_data), 32'(exp_q.pop_front()));
               end
            end
         end else begin
            if (run_len != 0) last_run = run_len;
            run_len = 0;
            low_run++;
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic push(input logic [7:0] pay[$]);
      foreach (pay[i]) begin
         pay_vld  = 1'b1;
         pay_data = pay[i];
         step();
      end
      pay_vld = 1'b0;
   endtask

   task automatic send_req(input logic [1:0] a, input logic [5:0] l,
                           input logic [7:0] pay[$], input logic perr);
      logic [7:0] p;
      int n;
      p = {l, a};
      exp_q.push_back(p);
      foreach (pay[i]) begin
         exp_q.push_back(pay[i]);
         p = p ^ pay[i];
      end
      exp_q.push_back(perr ? ~p : p);
      n = 0;
      while (req_rdy !== 1'b1 && n < 100) begin
         step();
         n++;
      end
      chk("req_rdy_wait", 32'(req_rdy), 32'd1);
      req_vld  = 1'b1;
      req_addr = a;
      req_len  = l;
`ifdef YAPP_TX_PERR_EN
      inject_perr = perr;
`endif
      step();
      req_vld = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int n;
      n = 0;
      while (pkt_done !== 1'b1 && n < 400) begin
         step();
         n++;
      end
      chk({tag, "_done"}, 32'(pkt_done), 32'd1);
      step();
      chk({tag, "_pulse"}, 32'(pkt_done), 32'd0);
   endtask

   initial begin
      logic [7:0] pl[$];
      logic [7:0] pb[$];
      logic       early;
      int         n;

      repeat (3) @(posedge clock);
      #1;
      chk("rst_req_rdy", 32'(req_rdy), 32'd0);
      chk("rst_vld", 32'(in_data_vld), 32'd0);
      chk("rst_data", 32'(in_data), 32'h00);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(pkt_done), 32'd0);
      chk("rst_count", 32'(pkt_count), 32'd0);
      reset = 1'b1;
      #1;
      chk("rel_req_rdy", 32'(req_rdy), 32'd1);
      chk("rel_pay_rdy", 32'(pay_rdy), 32'd1);
      step();

      pl = '{8'h11, 8'h22, 8'h33, 8'h44};
      push(pl);
      send_req(2'd1, 6'd4, pl, 1'b0);
      chk("t1_wait_busy", 32'(busy), 32'd1);
      chk("t1_wait_vld", 32'(in_data_vld), 32'd0);
      step();
      chk("t1_hdr", 32'({in_data_vld, in_data}), 32'h111);
      wait_done("t1");
      chk("t1_count", 32'(pkt_count), 32'd1);
      chk("t1_run", 32'(last_run), 32'd6);

      pl = {};
      send_req(2'd2, 6'd0, pl, 1'b0);
      wait_done("t2");
      chk("t2_run", 32'(last_run), 32'd2);
      chk("t2_gap", 32'(last_low >= GAP + 2), 32'd1);
      chk("t2_count", 32'(pkt_count), 32'd2);

      pl = '{8'h11, 8'h22, 8'h33, 8'h44};
      push(pl);
      send_req(2'd1, 6'd4, pl, 1'b0);
      n = 0;
      while (!(in_data_vld === 1'b1 && in_data === 8'h22) && n < 20) begin
         step();
         n++;
      end
      chk("t3_found", 32'(in_data), 32'h22);
      in_suspend = 1'b1;
      repeat (3) begin
         step();
         chk("t3_hold", 32'({in_data_vld, in_data}), 32'h122);
      end
      in_suspend = 1'b0;
      wait_done("t3");
      chk("t3_run", 32'(last_run), 32'd9);
      chk("t3_count", 32'(pkt_count), 32'd3);

      pl = {};
      for (int i = 0; i < 63; i++) pl.push_back(8'((i * 37 + 5) & 8'hFF));
      send_req(2'd3, 6'd63, pl, 1'b0);
      early = 1'b0;
      for (int i = 0; i < 63; i++) begin
         if (i == 62) chk("t4_no_early", 32'(early), 32'd0);
         pay_vld  = 1'b1;
         pay_data = pl[i];
         step();
         pay_vld = 1'b0;
         early = early | in_data_vld;
         if (i < 62) begin
            repeat (2) begin
               step();
               early = early | in_data_vld;
            end
         end
      end
      step();
      chk("t4_hdr", 32'({in_data_vld, in_data}), 32'h1FF);
      wait_done("t4");
      chk("t4_run", 32'(last_run), 32'd65);
      chk("t4_count", 32'(pkt_count), 32'd4);

      pl = '{8'hA1, 8'hA2};
      pb = '{8'hB1, 8'hB2};
      push(pl);
      push(pb);
      send_req(2'd0, 6'd2, pl, 1'b0);
      send_req(2'd1, 6'd2, pb, 1'b0);
      wait_done("bb");
      chk("bb_run", 32'(last_run), 32'd4);
      chk("bb_gap", 32'(last_low >= GAP + 2), 32'd1);
      chk("bb_count", 32'(pkt_count), 32'd6);

      pl = {};
      for (int i = 0; i < 10; i++) pl.push_back(8'(8'h40 + i));
      push(pl);
      send_req(2'd2, 6'd10, pl, 1'b0);
      n = 0;
      while (in_data_vld !== 1'b1 && n < 20) begin
         step();
         n++;
      end
      repeat (4) step();
      chk("t5_mid_vld", 32'(in_data_vld), 32'd1);
      reset = 1'b0;
      #1;
      chk("t5_vld_drop", 32'(in_data_vld), 32'd0);
      chk("t5_rst_rdy", 32'(req_rdy), 32'd0);
      exp_q.delete();
      step();
      reset = 1'b1;
      #1;
      chk("t5_rel_rdy", 32'(req_rdy), 32'd1);
      chk("t5_rel_count", 32'(pkt_count), 32'd0);
      chk("t5_rel_busy", 32'(busy), 32'd0);
      step();
      pl = '{8'h5A};
      send_req(2'd0, 6'd1, pl, 1'b0);
      repeat (10) step();
      chk("t5_fifo_empty", 32'({busy, in_data_vld}), 32'h2);
      push(pl);
      wait_done("t5");
      chk("t5_count", 32'(pkt_count), 32'd1);

`ifdef YAPP_TX_PERR_EN
      pl = '{8'h11, 8'h22, 8'h33, 8'h44};
      push(pl);
      send_req(2'd1, 6'd4, pl, 1'b1);
      wait_done("perr");
      inject_perr = 1'b0;
      chk("perr_count", 32'(pkt_count), 32'd2);
`endif

      repeat (4) step();
      chk("sb_drained", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
